// File: rtl/dut_pkg.sv
// Shared definitions for the multi-channel FIFO bank.
// Latency: n/a (constants and a width helper only).
// Backpressure: n/a.
//
// Holds the clog2 helper, the default geometry with its derived widths
// (address, pointer, count), and the indices used to address the error
// flag vectors (overflow / underflow) in the RTL and in the bench scoreboard.
package dut_pkg;

    // Ceiling log2; clog2(1) = 0, clog2(2) = 1, clog2(8) = 3.
    function automatic int clog2(input int value);
        int res;
        int rem;
        res = 0;
        rem = value - 1;
        while (rem > 0) begin
            res = res + 1;
            rem = rem >> 1;
        end
        return res;
    endfunction

    // Default geometry and derived widths.
    localparam int NCH_DEF   = 8;
    localparam int DEPTH_DEF = 4;
    localparam int WIDTH_DEF = 8;
    localparam int AW_DEF    = clog2(NCH_DEF);
    localparam int PW_DEF    = clog2(DEPTH_DEF);
    localparam int CW_DEF    = PW_DEF + 1;

    // Row indices of the packed error-flag arrays.
    localparam int ERR_OVF = 0;
    localparam int ERR_UNF = 1;
    localparam int ERR_N   = 2;

endpackage

// File: rtl/dut_fifo_ch.sv
// One FIFO channel: circular buffer with wr/rd pointers and an occupancy count.
// Latency: push visible at o_head/o_empty/o_full one edge after it is accepted.
// Backpressure: push on full is dropped (unless popped same cycle), pop on empty is ignored.
//
// Ports:
//   CLK, RST       clock, async active-high reset (pointers and count only)
//   i_push, i_data push strobe (already address-decoded and rdy-qualified) and payload
//   i_pop          pop strobe (already address-decoded and rdy-qualified)
//   o_head         head entry, 0 when empty
//   o_empty/o_full decoded from the registered count
//   o_ovf_evt      push attempted while full with no same-cycle pop
//   o_unf_evt      pop attempted while empty
module dut_fifo_ch
    import dut_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_head,
    output logic             o_empty,
    output logic             o_full,
    output logic             o_ovf_evt,
    output logic             o_unf_evt
);

    localparam int PW = clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;

    logic w_empty;
    logic w_full;
    logic w_push_ok;
    logic w_pop_ok;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == CW'(DEPTH));

    // A full channel is never empty, so a same-cycle pop always frees a slot
    // for the push. An empty channel has no bypass: the pop is refused even
    // when a push arrives in the same cycle.
    assign w_pop_ok  = i_pop & ~w_empty;
    assign w_push_ok = i_push & (~w_full | i_pop);

    assign o_ovf_evt = i_push & w_full & ~i_pop;
    assign o_unf_evt = i_pop & w_empty;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage is deliberately left out of reset; the count alone defines validity.
    always_ff @(posedge CLK) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    assign o_head  = w_empty ? '0 : r_mem[r_rd_ptr];
    assign o_empty = w_empty;
    assign o_full  = w_full;

endmodule

// File: rtl/dut_fifo_bank.sv
// NCH independent FIFOs behind one addressed write method and one addressed read method.
// Latency: push visible one edge later; read_data is the combinational head of read_address.
// Backpressure: rdy guards are 0 only in/just after reset; bad push/pop is dropped and flagged.
//
// Ports:
//   CLK, RST                       clock, async active-high reset
//   write_address/data/en, write_rdy   push method and its guard
//   read_address/en, read_data, read_rdy  pop method (actionvalue) and its guard
//   empty, full                    per-channel occupancy flags
//   ovf, unf                       sticky per-channel overflow / underflow flags
//   clr_err                        synchronous clear of ovf/unf (new events win)
module dut_fifo_bank
    import dut_pkg::*;
#(
    parameter int NCH   = 8,
    parameter int DEPTH = 4,
    parameter int WIDTH = 8,
    localparam int AW   = clog2(NCH)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [AW-1:0]    write_address,
    input  logic [WIDTH-1:0] write_data,
    input  logic             write_en,
    output logic             write_rdy,
    input  logic [AW-1:0]    read_address,
    input  logic             read_en,
    output logic [WIDTH-1:0] read_data,
    output logic             read_rdy,
    output logic [NCH-1:0]   empty,
    output logic [NCH-1:0]   full,
    output logic [NCH-1:0]   ovf,
    output logic [NCH-1:0]   unf,
    input  logic             clr_err
);

    logic                      r_wr_rdy;
    logic                      r_rd_rdy;
    logic [ERR_N-1:0][NCH-1:0] r_err;

    logic [NCH-1:0]            w_push_oh;
    logic [NCH-1:0]            w_pop_oh;
    logic [ERR_N-1:0][NCH-1:0] w_evt;
    logic [WIDTH-1:0]          w_head [NCH];

    // Strobes only count while the matching guard is up, so anything driven
    // during or right after reset is ignored.
    always_comb begin
        w_push_oh = '0;
        w_pop_oh  = '0;
        if (write_en && r_wr_rdy) begin
            w_push_oh[write_address] = 1'b1;
        end
        if (read_en && r_rd_rdy) begin
            w_pop_oh[read_address] = 1'b1;
        end
    end

    for (genvar c = 0; c < NCH; c++) begin : g_ch
        dut_fifo_ch #(
            .DEPTH (DEPTH),
            .WIDTH (WIDTH)
        ) u_ch (
            .CLK       (CLK),
            .RST       (RST),
            .i_push    (w_push_oh[c]),
            .i_data    (write_data),
            .i_pop     (w_pop_oh[c]),
            .o_head    (w_head[c]),
            .o_empty   (empty[c]),
            .o_full    (full[c]),
            .o_ovf_evt (w_evt[ERR_OVF][c]),
            .o_unf_evt (w_evt[ERR_UNF][c])
        );
    end

    // Channel heads are already zero when empty, which also covers reset.
    assign read_data = w_head[read_address];

    // Guards: low in reset, registered high on the first edge afterwards.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_wr_rdy <= 1'b0;
            r_rd_rdy <= 1'b0;
        end else begin
            r_wr_rdy <= 1'b1;
            r_rd_rdy <= 1'b1;
        end
    end

    // Sticky error flags; an event in the clearing cycle survives the clear.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_err <= '0;
        end else if (clr_err) begin
            r_err <= w_evt;
        end else begin
            r_err <= r_err | w_evt;
        end
    end

    assign write_rdy = r_wr_rdy;
    assign read_rdy  = r_rd_rdy;
    assign ovf       = r_err[ERR_OVF];
    assign unf       = r_err[ERR_UNF];

endmodule

// File: tb/tb_dut_fifo_bank.sv
// Self-checking bench for dut_fifo_bank: directed scenarios then random traffic,
// all compared against a queue-per-channel reference model.
module tb_dut_fifo_bank;
    import dut_pkg::*;

    localparam int NCH   = 8;
    localparam int DEPTH = 4;

    logic                CLK;
    logic                RST;
    logic [AW_DEF-1:0]   write_address;
    logic [7:0]          write_data;
    logic                write_en;
    logic                write_rdy;
    logic [AW_DEF-1:0]   read_address;
    logic                read_en;
    logic [7:0]          read_data;
    logic                read_rdy;
    logic [NCH-1:0]      empty;
    logic [NCH-1:0]      full;
    logic [NCH-1:0]      ovf;
    logic [NCH-1:0]      unf;
    logic                clr_err;

    dut_fifo_bank #(
        .NCH   (NCH),
        .DEPTH (DEPTH),
        .WIDTH (8)
    ) dut (
        .CLK           (CLK),
        .RST           (RST),
        .write_address (write_address),
        .write_data    (write_data),
        .write_en      (write_en),
        .write_rdy     (write_rdy),
        .read_address  (read_address),
        .read_en       (read_en),
        .read_data     (read_data),
        .read_rdy      (read_rdy),
        .empty         (empty),
        .full          (full),
        .ovf           (ovf),
        .unf           (unf),
        .clr_err       (clr_err)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Reference model: one queue per channel plus sticky flag vectors.
    logic [7:0]     mq [NCH][$];
    logic [NCH-1:0] m_err [ERR_N];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int c = 0; c < NCH; c++) mq[c].delete();
        m_err[ERR_OVF] = '0;
        m_err[ERR_UNF] = '0;
    endtask

    task automatic model_update(input bit we, input int wa, input logic [7:0] wd,
                                input bit re, input int ra, input bit clr);
        int             szw;
        int             szr;
        bit             pop_ok;
        bit             push_ok;
        logic [NCH-1:0] ov;
        logic [NCH-1:0] un;
        szw     = mq[wa].size();
        szr     = mq[ra].size();
        ov      = '0;
        un      = '0;
        pop_ok  = re && (szr > 0);
        // Full channel accepts a push only when the same channel is popped.
        push_ok = we && ((szw < DEPTH) || (re && (ra == wa)));
        if (re && !pop_ok) un[ra] = 1'b1;
        if (we && !push_ok) ov[wa] = 1'b1;
        if (pop_ok) void'(mq[ra].pop_front());
        if (push_ok) mq[wa].push_back(wd);
        m_err[ERR_OVF] = clr ? ov : (m_err[ERR_OVF] | ov);
        m_err[ERR_UNF] = clr ? un : (m_err[ERR_UNF] | un);
    endtask

    task automatic check_outputs();
        logic [NCH-1:0] e_empty;
        logic [NCH-1:0] e_full;
        logic [7:0]     e_rd;
        int             ra;
        ra = int'(read_address);
        for (int c = 0; c < NCH; c++) begin
            e_empty[c] = (mq[c].size() == 0);
            e_full[c]  = (mq[c].size() == DEPTH);
        end
        e_rd = (mq[ra].size() > 0) ? mq[ra][0] : 8'h00;
        chk("empty", empty, e_empty);
        chk("full", full, e_full);
        chk("ovf", ovf, m_err[ERR_OVF]);
        chk("unf", unf, m_err[ERR_UNF]);
        chk("read_data", read_data, e_rd);
    endtask

    // One clock of traffic. Called just after a rising edge; outputs are
    // sampled on the falling edge, the model advances at the next rising edge.
    task automatic step(input bit we, input int wa, input logic [7:0] wd,
                        input bit re, input int ra, input bit clr,
                        output logic [7:0] rd);
        write_en      = we;
        write_address = AW_DEF'(wa);
        write_data    = wd;
        read_en       = re;
        read_address  = AW_DEF'(ra);
        clr_err       = clr;
        @(negedge CLK);
        check_outputs();
        rd = read_data;
        @(posedge CLK);
        model_update(we, wa, wd, re, ra, clr);
        #1;
        write_en = 1'b0;
        read_en  = 1'b0;
        clr_err  = 1'b0;
    endtask

    task automatic push(input int ch, input logic [7:0] d);
        logic [7:0] rd;
        step(1'b1, ch, d, 1'b0, ch, 1'b0, rd);
    endtask

    task automatic pop(input int ch, output logic [7:0] rd);
        step(1'b0, ch, 8'h00, 1'b1, ch, 1'b0, rd);
    endtask

    // Asynchronous reset in the middle of a cycle, optionally with strobes
    // held active across it (they must have no effect).
    task automatic do_reset(input bit in_flight);
        write_en      = in_flight;
        write_address = AW_DEF'(4);
        write_data    = 8'hEE;
        read_en       = in_flight;
        #2;
        RST = 1'b1;
        #1;
        chk("rst_empty", empty, 8'hFF);
        chk("rst_full", full, 8'h00);
        chk("rst_read_data", read_data, 8'h00);
        chk("rst_write_rdy", 8'(write_rdy), 8'h00);
        chk("rst_read_rdy", 8'(read_rdy), 8'h00);
        chk("rst_ovf", ovf, 8'h00);
        chk("rst_unf", unf, 8'h00);
        model_clear();
        @(posedge CLK);
        #1;
        chk("rst_hold_rdy", 8'(write_rdy), 8'h00);
        @(negedge CLK);
        RST      = 1'b0;
        write_en = 1'b0;
        read_en  = 1'b0;
        #1;
        chk("rdy_before_edge", 8'(read_rdy), 8'h00);
        @(posedge CLK);
        #1;
        chk("rdy_after_edge_w", 8'(write_rdy), 8'h01);
        chk("rdy_after_edge_r", 8'(read_rdy), 8'h01);
        chk("post_rst_empty", empty, 8'hFF);
    endtask

    logic [7:0] rd;

    initial begin
        RST           = 1'b0;
        write_address = '0;
        write_data    = '0;
        write_en      = 1'b0;
        read_address  = '0;
        read_en       = 1'b0;
        clr_err       = 1'b0;
        model_clear();
        @(posedge CLK);
        #1;
        do_reset(1'b0);

        // Fill channel 3.
        push(3, 8'h11);
        push(3, 8'h22);
        push(3, 8'h33);
        push(3, 8'h44);
        chk("fill_full", full, 8'h08);
        chk("fill_empty", empty, 8'hF7);

        // Drain channel 3 in order, then underflow.
        pop(3, rd); chk("drain0", rd, 8'h11);
        pop(3, rd); chk("drain1", rd, 8'h22);
        pop(3, rd); chk("drain2", rd, 8'h33);
        pop(3, rd); chk("drain3", rd, 8'h44);
        chk("drain_empty", empty, 8'hFF);
        pop(3, rd); chk("unf_data", rd, 8'h00);
        chk("unf_flag", unf, 8'h08);

        // Overflow on channel 5, then a push that rides on a same-cycle pop.
        for (int i = 0; i < 4; i++) push(5, 8'hA0 + 8'(i));
        push(5, 8'hB0);
        chk("ovf_flag", ovf, 8'h20);
        step(1'b1, 5, 8'hB1, 1'b1, 5, 1'b0, rd);
        chk("full_pushpop_data", rd, 8'hA0);
        chk("full_pushpop_ovf", ovf, 8'h20);
        chk("full_pushpop_full", full, 8'h20);
        pop(5, rd); chk("ovf_drain0", rd, 8'hA1);
        pop(5, rd); chk("ovf_drain1", rd, 8'hA2);
        pop(5, rd); chk("ovf_drain2", rd, 8'hA3);
        pop(5, rd); chk("ovf_drain3", rd, 8'hB1);

        // Empty channel 0: same-cycle push and pop, no bypass.
        step(1'b1, 0, 8'h5A, 1'b1, 0, 1'b0, rd);
        chk("empty_pushpop_data", rd, 8'h00);
        chk("empty_pushpop_unf", unf, 8'h09);
        chk("empty_pushpop_nonempty", 8'(empty[0]), 8'h00);
        pop(0, rd); chk("empty_pushpop_later", rd, 8'h5A);

        // Pointer wrap on channel 7.
        for (int i = 0; i < 10; i++) begin
            push(7, 8'h70 + 8'(i));
            pop(7, rd);
            chk("wrap_data", rd, 8'h70 + 8'(i));
        end

        // Clear coincident with a new overflow on channel 2.
        for (int i = 0; i < 4; i++) push(2, 8'hC0 + 8'(i));
        step(1'b1, 2, 8'hCF, 1'b0, 2, 1'b1, rd);
        chk("clr_ovf", ovf, 8'h04);
        chk("clr_unf", unf, 8'h00);

        // Reset while channel 1 holds two entries.
        push(1, 8'h61);
        push(1, 8'h62);
        step(1'b0, 0, 8'h00, 1'b0, 1, 1'b0, rd);
        chk("pre_rst_head", rd, 8'h61);
        read_address = AW_DEF'(1);
        do_reset(1'b1);

        // Random traffic, biased onto a few channels so full/empty edges occur.
        for (int i = 0; i < 3000; i++) begin
            bit         we;
            bit         re;
            bit         clr;
            int         wa;
            int         ra;
            logic [7:0] wd;
            we  = ($urandom_range(0, 99) < 60);
            re  = ($urandom_range(0, 99) < 50);
            clr = ($urandom_range(0, 99) < 3);
            wa  = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 1)) : int'($urandom_range(0, NCH - 1));
            ra  = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 1)) : int'($urandom_range(0, NCH - 1));
            wd  = 8'($urandom);
            step(we, wa, wd, re, ra, clr, rd);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dut_fifo_bank.md
# dut_fifo_bank

Parametrised multi-channel successor to the single-bit addressed store. It provides NCH independent FIFOs, each DEPTH entries of WIDTH bits, behind the same addressed write/read method pair with en/rdy handshakes. Per-channel occupancy and sticky error flags are added. It sits directly under the test wrapper in place of the original store and is driven by the same bench-side method drivers.

## Interface
- NCH, 8: number of channels; power of two, 2..16
- DEPTH, 4: entries per channel; power of two, 2..64
- WIDTH, 8: data bits per entry, 1..32
- AW, log2(NCH): derived address width; not overridden
- CLK  input  1  single clock, rising edge
- RST  input  1  asynchronous, active-high reset
- write_address  input  AW  target channel for push
- write_data  input  WIDTH  push payload
- write_en  input  1  push strobe; legal only while write_rdy=1
- write_rdy  output  1  write method guard
- read_address  input  AW  source channel for pop
- read_en  input  1  pop strobe; legal only while read_rdy=1
- read_data  output  WIDTH  head of read_address channel, combinational
- read_rdy  output  1  read method guard
- empty  output  NCH  bit c = channel c holds 0 entries
- full  output  NCH  bit c = channel c holds DEPTH entries
- ovf  output  NCH  sticky: push attempted on full channel c
- unf  output  NCH  sticky: pop attempted on empty channel c
- clr_err  input  1  synchronous clear of ovf/unf

## Operation
- Each channel is a circular buffer with wr_ptr and rd_ptr of log2(DEPTH) bits and a count of log2(DEPTH)+1 bits. Pointers wrap DEPTH-1 to 0 naturally.
- Push: write_en & write_rdy & !full[write_address] stores write_data at wr_ptr, increments wr_ptr and count.
- Pop: read_en & read_rdy & !empty[read_address] increments rd_ptr and decrements count.
- read_data = head entry of read_address channel when it is non-empty, else 0. It is valid in the same cycle as read_en (actionvalue semantics).
- Push to full channel: dropped; ovf[c] set; no state change.
- Pop from empty channel: read_data=0; unf[c] set; no state change.
- Same channel, push+pop in one cycle:
  - non-empty, non-full: both occur; count unchanged.
  - full: pop frees a slot and push is accepted; no ovf.
  - empty: no bypass; pop is underflow (unf set, read_data=0); push accepted; count becomes 1.
- Different channels, push+pop in one cycle: fully independent.
- clr_err=1 clears all ovf/unf at the edge. An error event in the same cycle as clr_err wins: its bit is set.
- write_rdy and read_rdy are not argument-dependent. Both are 0 in reset and 1 otherwise.

## Timing
- Reset (async assert): counts, pointers, ovf, unf and both rdy go to 0 immediately. empty goes to all-ones, full to all-zeros, read_data to 0. Storage contents are not reset.
- write_rdy and read_rdy rise on the first CLK rising edge after RST deasserts (registered).
- Push latency: entry is visible on read_data / empty / full the cycle after the accepting edge.
- Pop: read_data shows the next entry the cycle after the popping edge.
- empty, full, ovf and unf are registered (or decoded from registered count) and update one edge after the causing event.
- Reset mid-operation: all channels empty on the following cycle; in-flight strobes during RST are ignored.
- No combinational path from write_* to read_data, except through the registered state.

## Structure
- Package dut_pkg holds:
  - clog2 helper function;
  - derived widths (AW, PW = log2(DEPTH), CW = PW+1);
  - error-flag index constants shared with the bench scoreboard.
- Sub-module dut_fifo_ch: one channel with storage, pointers, count, empty/full, push/pop inputs and head output. It is instantiated NCH times via generate.
- Top level holds:
  - address decode to per-channel push/pop one-hots;
  - read_data mux;
  - ovf/unf flag registers;
  - rdy registers.

## Test plan
- Reset, then fill: RST pulse → rdy=0 during reset, rdy=1 one edge later, empty=8'hFF. Push 0x11,0x22,0x33,0x44 to ch 3 → full[3]=1, count 4, other channels untouched.
- Drain: pop ch 3 four times → read_data 0x11,0x22,0x33,0x44 in order; then empty[3]=1. A fifth pop gives read_data=0 and unf[3]=1.
- Overflow with simultaneous pop: ch 5 full with 0xA0..0xA3. Push 0xB0 alone → dropped, ovf[5]=1. Push 0xB1 + pop ch 5 in the same cycle → 0xA0 returned, 0xB1 accepted, no further error. Drain yields 0xA1,0xA2,0xA3,0xB1.
- Empty same-cycle push+pop on ch 0 with 0x5A → read_data=0, unf[0]=1, count becomes 1. A later pop returns 0x5A.
- Wrap-around: 10 interleaved push/pop pairs on ch 7 with incrementing data → pointers wrap twice, data order preserved, never full.
- Error clear and mid-op reset: clr_err coincident with a new overflow on ch 2 → ovf=8'h04 only. Assert RST while ch 1 holds 2 entries → empty[1]=1 immediately and read_data=0.
